// File: rtl/alu_pkg.sv
// Shared ALU definitions: fixed-point format, reciprocal FSM states
// and sign-magnitude field extraction.
package alu_pkg;

   localparam int WIDTH   = 24;
   localparam int FRAC    = 14;
   localparam int ONE_FX  = 1 << FRAC;
   localparam int MAG_MAX = (1 << (WIDTH - 1)) - 1;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      FIN,
      DONE
   } recip_state_t;

   typedef struct packed {
      logic             sgn;
      logic [WIDTH-2:0] mag;
   } sm_t;

   function automatic sm_t sm_split(input logic [WIDTH-1:0] v);
      sm_t f;
      f.sgn = v[WIDTH-1];
      f.mag = v[WIDTH-2:0];
      return f;
   endfunction

endpackage

// File: rtl/recip_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract
// the divisor, keep the difference only when it does not underflow.
module recip_divstep #(
   parameter int W = 24
) (
   input  logic [W-1:0] rem,
   input  logic         d,
   input  logic [W-2:0] mag,
   output logic [W-1:0] rem_nx,
   output logic         q_bit
);

   logic [W:0]   shifted;
   logic [W-1:0] trial;

   assign shifted = {rem, d};
   assign q_bit   = (shifted >= {2'b00, mag});
   // rem < mag is invariant, so the low W bits hold the full difference
   assign trial   = shifted[W-1:0] - {1'b0, mag};
   assign rem_nx  = q_bit ? trial : shifted[W-1:0];

endmodule

// File: rtl/alu_recip_s9_14.sv
// Iterative S9.14 reciprocal: 2^(2*FRAC) / |R|, one quotient bit per
// cycle, then saturate and re-attach the sign.
module alu_recip_s9_14
   import alu_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int FRAC  = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] result,
   output logic             sign,
   output logic             cont,
   output logic             busy,
   output logic             sat
);

   localparam int QBITS = 2 * FRAC + 1;
   localparam int CW    = $clog2(QBITS);

   recip_state_t     state;
   sm_t              op;
   logic             sgn;
   logic [WIDTH-2:0] mag;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] rem_nx;
   logic [QBITS-1:0] q;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             q_bit;

   assign op   = sm_split(R);
   // the dividend is a single 1 at its top bit
   assign d    = (cnt == CW'(QBITS - 1));
   assign sign = result[WIDTH-1];

   recip_divstep #(.W(WIDTH)) u_step (
      .rem    (rem),
      .d      (d),
      .mag    (mag),
      .rem_nx (rem_nx),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         result <= '0;
         cont   <= 1'b0;
         busy   <= 1'b0;
         sat    <= 1'b0;
         sgn    <= 1'b0;
         mag    <= '0;
         rem    <= '0;
         q      <= '0;
         cnt    <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  sgn   <= op.sgn;
                  mag   <= op.mag;
                  rem   <= '0;
                  q     <= '0;
                  cnt   <= CW'(QBITS - 1);
                  cont  <= 1'b0;
                  busy  <= 1'b1;
                  state <= DIV;
               end
            end
            DIV: begin
               rem <= rem_nx;
               q   <= {q[QBITS-2:0], q_bit};
               if (cnt == '0) state <= FIN;
               else cnt <= cnt - 1'b1;
            end
            FIN: begin
               if (mag == '0 || q > QBITS'(MAG_MAX)) begin
                  result <= {sgn, {(WIDTH-1){1'b1}}};
                  sat    <= 1'b1;
               end else begin
                  result <= {sgn, q[WIDTH-2:0]};
                  sat    <= 1'b0;
               end
               cont  <= 1'b1;
               busy  <= 1'b0;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
